// File: rtl/fb_port_arbiter.sv
// Framebuffer RAM port-1 arbiter: rasterizer/host round-robin plus a
// full-buffer clear engine that owns the port while it runs.
module fb_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_,
    input  logic                  clr_start,
    input  logic [DATA_WIDTH-1:0] clr_color,
    output logic                  clr_busy,
    output logic                  clr_done,
    input  logic                  rast_req,
    input  logic [ADDR_WIDTH-1:0] rast_addr,
    input  logic [DATA_WIDTH-1:0] rast_data,
    output logic                  rast_gnt,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we_,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] color;
    logic                  last_host;
    logic                  rd_pend;
    logic                  blocked;

    // The clear owns the port from the cycle clr_start is seen.
    assign blocked  = clr_start || (state == CLEAR);
    assign rast_gnt = !blocked && rast_req && (!host_req || last_host);
    assign host_gnt = !blocked && host_req && (!rast_req || !last_host);

    assign clr_busy   = (state == CLEAR);
    assign host_rdata = host_rvalid ? ram_q : '0;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state       <= IDLE;
            cnt         <= '0;
            color       <= '0;
            last_host   <= 1'b1;
            rd_pend     <= 1'b0;
            host_rvalid <= 1'b0;
            clr_done    <= 1'b0;
            ram_we_     <= 1'b1;
            ram_addr    <= '0;
            ram_data    <= '0;
        end else begin
            ram_we_     <= 1'b1;
            clr_done    <= 1'b0;
            rd_pend     <= host_gnt && !host_we;
            host_rvalid <= rd_pend;
            unique case (state)
                IDLE: begin
                    if (clr_start) begin
                        state <= CLEAR;
                        color <= clr_color;
                        cnt   <= '0;
                    end
                    unique case (1'b1)
                        rast_gnt: begin
                            ram_addr  <= rast_addr;
                            ram_data  <= rast_data;
                            ram_we_   <= 1'b0;
                            last_host <= 1'b0;
                        end
                        host_gnt: begin
                            ram_addr  <= host_addr;
                            ram_data  <= host_wdata;
                            ram_we_   <= !host_we;
                            last_host <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                CLEAR: begin
                    ram_addr <= cnt;
                    ram_data <= color;
                    ram_we_  <= 1'b0;
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state    <= IDLE;
                        clr_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a synchronous RAM model on port 1.
module tb_fb_port_arbiter;

    logic       clock = 1'b0;
    logic       reset_;
    logic       clr_start;
    logic [7:0] clr_color;
    logic       clr_busy;
    logic       clr_done;
    logic       rast_req;
    logic [7:0] rast_addr;
    logic [7:0] rast_data;
    logic       rast_gnt;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic       host_rvalid;
    logic [7:0] host_rdata;
    logic [7:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we_;
    logic [7:0] ram_q;

    logic [7:0] mem [256];

    int errors = 0;
    int checks = 0;

    fb_port_arbiter dut (
        .clock      (clock),
        .reset_     (reset_),
        .clr_start  (clr_start),
        .clr_color  (clr_color),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .rast_req   (rast_req),
        .rast_addr  (rast_addr),
        .rast_data  (rast_data),
        .rast_gnt   (rast_gnt),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_we_    (ram_we_),
        .ram_q      (ram_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!ram_we_) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_ = 1'b1;
    endtask

    initial begin
        int  bad;
        int  ndone;
        int  nwr;
        bit  found;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        ram_q      = 8'h00;
        reset_     = 1'b0;
        clr_start  = 1'b0;
        clr_color  = 8'h00;
        rast_req   = 1'b0;
        rast_addr  = 8'h00;
        rast_data  = 8'h00;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = 8'h00;
        host_wdata = 8'h00;
        @(negedge clock);
        do_reset();

        // reset values
        chk("rst_we_", ram_we_, 1);
        chk("rst_addr", ram_addr, 0);
        chk("rst_data", ram_data, 0);
        chk("rst_busy", clr_busy, 0);
        chk("rst_done", clr_done, 0);
        chk("rst_rvalid", host_rvalid, 0);
        chk("rst_rdata", host_rdata, 0);

        // single rasterizer write
        rast_req = 1; rast_addr = 8'h10; rast_data = 8'hAB;
        #1;
        chk("rast_gnt", rast_gnt, 1);
        chk("rast_hgnt", host_gnt, 0);
        @(negedge clock);
        rast_req = 0;
        chk("rast_we_", ram_we_, 0);
        chk("rast_addr", ram_addr, 8'h10);
        chk("rast_data", ram_data, 8'hAB);
        @(negedge clock);
        chk("rast_mem", mem[8'h10], 8'hAB);
        chk("idle_we_", ram_we_, 1);
        chk("idle_addr", ram_addr, 8'h10);

        // host write then host read of 0x22
        host_req = 1; host_we = 1; host_addr = 8'h22; host_wdata = 8'h5C;
        #1;
        chk("hw_gnt", host_gnt, 1);
        @(negedge clock);
        chk("hw_we_", ram_we_, 0);
        host_we = 0; host_wdata = 8'h00;
        #1;
        chk("hr_gnt", host_gnt, 1);
        @(negedge clock);
        host_req = 0;
        chk("hr_we_", ram_we_, 1);
        chk("hr_rv1", host_rvalid, 0);
        @(negedge clock);
        chk("hr_rv2", host_rvalid, 1);
        chk("hr_data", host_rdata, 8'h5C);
        @(negedge clock);
        chk("hr_rv3", host_rvalid, 0);
        chk("hr_data0", host_rdata, 0);

        // round-robin tie after reset
        do_reset();
        rast_req = 1; rast_addr = 8'h30; rast_data = 8'h11;
        host_req = 1; host_we = 1; host_addr = 8'h31; host_wdata = 8'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d_rast", k), rast_gnt, (k % 2) == 0);
            chk($sformatf("rr%0d_host", k), host_gnt, (k % 2) == 1);
            @(negedge clock);
        end
        host_req = 0;

        // full clear with rasterizer held
        clr_start = 1; clr_color = 8'h3F;
        #1;
        chk("cs_gnt", rast_gnt | host_gnt, 0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            clr_start = 0;
            if (!clr_busy || rast_gnt || host_gnt) bad++;
            if (i >= 1 && (ram_we_ || ram_addr != 8'(i - 1)
                           || ram_data != 8'h3F)) bad++;
        end
        chk("clr_window", bad, 0);
        @(negedge clock);
        chk("clr_done", clr_done, 1);
        chk("clr_busy0", clr_busy, 0);
        chk("clr_last", ram_addr, 8'hFF);
        chk("post_rgnt", rast_gnt, 1);
        @(negedge clock);
        rast_req = 0;
        chk("done_pulse", clr_done, 0);
        @(negedge clock);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (i != 8'h30 && mem[i] != 8'h3F) bad++;
        chk("clr_mem", bad, 0);
        chk("post_mem", mem[8'h30], 8'h11);

        // reset in the middle of a clear
        clr_start = 1; clr_color = 8'h77;
        @(negedge clock);
        clr_start = 0;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (ram_addr == 8'd100 && !ram_we_) found = 1;
            else @(negedge clock);
        end
        chk("abort_reach", found, 1);
        reset_ = 0;
        #1;
        chk("abort_we_", ram_we_, 1);
        chk("abort_addr", ram_addr, 0);
        chk("abort_data", ram_data, 0);
        chk("abort_busy", clr_busy, 0);
        @(negedge clock);
        reset_ = 1;
        ndone = 0;
        nwr = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (clr_done) ndone++;
            if (!ram_we_) nwr++;
        end
        chk("abort_ndone", ndone, 0);
        chk("abort_nwr", nwr, 0);
        bad = 0;
        for (int i = 100; i < 256; i++)
            if (mem[i] != 8'h3F) bad++;
        chk("abort_mem_hi", bad, 0);
        chk("abort_mem99", mem[99], 8'h77);

        // reset discards an outstanding host read
        host_req = 1; host_we = 0; host_addr = 8'h22;
        #1;
        chk("rd_rst_gnt", host_gnt, 1);
        @(negedge clock);
        host_req = 0;
        reset_ = 0;
        #2;
        reset_ = 1;
        @(negedge clock);
        chk("rd_rst_rv", host_rvalid, 0);
        @(negedge clock);
        chk("rd_rst_rv2", host_rvalid, 0);

        // host read accepted just before a clear
        host_req = 1; host_we = 1; host_addr = 8'h05; host_wdata = 8'h9D;
        @(negedge clock);
        host_we = 0;
        #1;
        chk("pre_gnt", host_gnt, 1);
        @(negedge clock);
        host_req = 0;
        clr_start = 1; clr_color = 8'h42;
        @(negedge clock);
        clr_start = 0;
        chk("pre_busy", clr_busy, 1);
        chk("pre_rv", host_rvalid, 1);
        chk("pre_rdata", host_rdata, 8'h9D);
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clock);
            if (clr_done) found = 1;
        end
        chk("pre_done", found, 1);
        @(negedge clock);
        chk("pre_mem5", mem[8'h05], 8'h42);
        chk("pre_memff", mem[8'hFF], 8'h42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
